// File: rtl/iic_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding, ACK/NACK levels, byte width.
// Pure declarations; no logic, no latency.
package iic_pkg;
   localparam int   IIC_BYTE_W = 8;
   localparam logic IIC_ACK    = 1'b0;
   localparam logic IIC_NACK   = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_WR_DATA,
      S_WR_ACK,
      S_RD_DATA,
      S_RD_ACK,
      S_WAIT_STOP
   } iic_slv_state_t;
endpackage

// File: rtl/iic_line_filter.sv
// Two-flop synchronizer, FILT-sample stability filter and one-clk rise/fall strobes for one bus line.
// Latency: 2 + FILT clk from pin change to filtered change and strobe; no backpressure.
module iic_line_filter #(
   parameter int FILT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic line,
   output logic rise,
   output logic fall
);
   logic [1:0] sync;
   logic [3:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= 2'b11;
         cnt  <= '0;
         line <= 1'b1;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         sync <= {sync[0], din};
         rise <= 1'b0;
         fall <= 1'b0;
         // cnt counts consecutive synced samples that disagree with the filtered level
         if (sync[1] == line) begin
            cnt <= '0;
         end else if (cnt == 4'(FILT - 1)) begin
            line <= sync[1];
            cnt  <= '0;
            rise <= sync[1];
            fall <= ~sync[1];
         end else begin
            cnt <= cnt + 4'd1;
         end
      end
   end
endmodule

// File: rtl/iic_slave.sv
// I2C target: filtered SCL/SDA, START/STOP detection, 7-bit address match, byte write/read to a local register file.
// Acts one clk after a filtered SCL edge; never stretches SCL, so rd_data must be ready before the next SCL fall.
module iic_slave
   import iic_pkg::*;
#(
   parameter logic [6:0] ADDR = 7'h50,
   parameter int          FILT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  scl_i,
   input  logic                  sda_i,
   output logic                  sda_oe,
   output logic                  busy,
   output logic                  wr_valid,
   output logic [IIC_BYTE_W-1:0] wr_data,
   output logic                  wr_first,
   output logic                  rd_req,
   input  logic [IIC_BYTE_W-1:0] rd_data,
   output logic                  stop_o
);
   logic scl, sda, scl_rise, scl_fall, sda_rise, sda_fall;
   logic start_det, stop_det;
   logic [IIC_BYTE_W-1:0] shreg, rx_byte;
   logic [2:0] bit_cnt;
   logic rw, first_arm;
   iic_slv_state_t state;

   iic_line_filter #(.FILT(FILT)) u_scl_filt (
      .clk  (clk),
      .rst  (rst),
      .din  (scl_i),
      .line (scl),
      .rise (scl_rise),
      .fall (scl_fall)
   );

   iic_line_filter #(.FILT(FILT)) u_sda_filt (
      .clk  (clk),
      .rst  (rst),
      .din  (sda_i),
      .line (sda),
      .rise (sda_rise),
      .fall (sda_fall)
   );

   // An SDA edge coinciding with an SCL rise is a data bit, not a bus condition
   assign start_det = sda_fall & scl & ~scl_rise;
   assign stop_det  = sda_rise & scl & ~scl_rise;
   assign rx_byte   = {shreg[IIC_BYTE_W-2:0], sda};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         rw        <= 1'b0;
         first_arm <= 1'b0;
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         wr_valid  <= 1'b0;
         wr_data   <= '0;
         wr_first  <= 1'b0;
         rd_req    <= 1'b0;
         stop_o    <= 1'b0;
      end else begin
         wr_valid <= 1'b0;
         rd_req   <= 1'b0;
         stop_o   <= 1'b0;
         if (start_det) begin
            state   <= S_ADDR;
            bit_cnt <= 3'd7;
            sda_oe  <= 1'b0;
            busy    <= 1'b1;
         end else if (stop_det) begin
            state     <= S_IDLE;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            stop_o    <= 1'b1;
            first_arm <= 1'b0;
         end else begin
            case (state)
               S_IDLE, S_WAIT_STOP: ;
               S_ADDR: if (scl_rise) begin
                  shreg   <= rx_byte;
                  bit_cnt <= bit_cnt - 3'd1;
                  if (bit_cnt == 3'd0) begin
                     if (rx_byte[7:1] == ADDR) begin
                        state <= S_ADDR_ACK;
                        rw    <= rx_byte[0];
                     end else begin
                        state <= S_WAIT_STOP;
                     end
                  end
               end
               // sda_oe doubles as the phase flag: low during bit 8 tail, high during the ACK bit
               S_ADDR_ACK: begin
                  if (scl_rise && sda_oe && rw)
                     rd_req <= 1'b1;
                  if (scl_fall) begin
                     if (!sda_oe) begin
                        sda_oe <= 1'b1;
                     end else begin
                        bit_cnt <= 3'd7;
                        if (rw) begin
                           state  <= S_RD_DATA;
                           shreg  <= rd_data;
                           sda_oe <= ~rd_data[IIC_BYTE_W-1];
                        end else begin
                           state     <= S_WR_DATA;
                           first_arm <= 1'b1;
                           sda_oe    <= 1'b0;
                        end
                     end
                  end
               end
               S_WR_DATA: if (scl_rise) begin
                  shreg   <= rx_byte;
                  bit_cnt <= bit_cnt - 3'd1;
                  if (bit_cnt == 3'd0) begin
                     wr_data   <= rx_byte;
                     wr_valid  <= 1'b1;
                     wr_first  <= first_arm;
                     first_arm <= 1'b0;
                     state     <= S_WR_ACK;
                  end
               end
               S_WR_ACK: if (scl_fall) begin
                  if (!sda_oe) begin
                     sda_oe <= 1'b1;
                  end else begin
                     sda_oe  <= 1'b0;
                     bit_cnt <= 3'd7;
                     state   <= S_WR_DATA;
                  end
               end
               S_RD_DATA: if (scl_fall) begin
                  if (bit_cnt == 3'd0) begin
                     sda_oe <= 1'b0;
                     state  <= S_RD_ACK;
                  end else begin
                     shreg   <= {shreg[IIC_BYTE_W-2:0], 1'b0};
                     sda_oe  <= ~shreg[IIC_BYTE_W-2];
                     bit_cnt <= bit_cnt - 3'd1;
                  end
               end
               // Any fall seen here follows an ACK; a NACK leaves the state on the rise
               S_RD_ACK: begin
                  if (scl_rise) begin
                     if (sda == IIC_ACK) begin
                        rd_req <= 1'b1;
                     end else begin
                        state  <= S_WAIT_STOP;
                        sda_oe <= 1'b0;
                     end
                  end else if (scl_fall) begin
                     shreg   <= rd_data;
                     sda_oe  <= ~rd_data[IIC_BYTE_W-1];
                     bit_cnt <= 3'd7;
                     state   <= S_RD_DATA;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule
